// File: rtl/vgachargen_apb_if_pkg.sv
// Shared types and constants for the vgachargen APB port-A front end.
package vgachargen_apb_if_pkg;

  localparam int CH_MAP_ADDR_WIDTH  = 12;
  localparam int CH_MAP_DATA_WIDTH  = 8;
  localparam int COL_MAP_ADDR_WIDTH = 12;
  localparam int CH_T_ADDR_WIDTH    = 8;
  localparam int CH_T_DATA_WIDTH    = 128;

  // 80x30 text screen
  localparam int          CH_MAP_SIZE = 2400;
  localparam logic [31:0] CTRL_ID     = 32'h5647_4331;

  typedef enum logic [1:0] {
    REGION_CH_MAP  = 2'b00,
    REGION_COL_MAP = 2'b01,
    REGION_CH_T    = 2'b10,
    REGION_CTRL    = 2'b11
  } region_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/vgachargen_apb_if_if.sv
// APB3 bus bundle; members keep the slave-side port names of vgachargen_apb_if.
interface vgachargen_apb_if_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          psel_i;
  logic          penable_i;
  logic          pwrite_i;
  logic [AW-1:0] paddr_i;
  logic [DW-1:0] pwdata_i;
  logic [DW-1:0] prdata_o;
  logic          pready_o;
  logic          pslverr_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/vgachargen_apb_if.sv
// APB3 slave owning port A of ch_map/col_map/ch_t_rw; every access takes exactly 2 wait states.
// Define VGACHARGEN_APB_PSLVERR_EN to report out-of-range map accesses and ctrl writes on PSLVERR.
module vgachargen_apb_if
  import vgachargen_apb_if_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  vgachargen_apb_if_if.slave            apb,
  output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_o,
  output logic                          ch_map_wen_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_i,
  output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [7:0]                    col_map_data_o,
  output logic                          col_map_wen_o,
  input  logic [7:0]                    col_map_data_i,
  output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_o,
  output logic                          ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_i
);

  function automatic logic [CH_T_DATA_WIDTH-1:0] rmw_merge(
    input logic [CH_T_DATA_WIDTH-1:0] row,
    input logic [1:0]                 slice,
    input logic [31:0]                word
  );
    logic [CH_T_DATA_WIDTH-1:0] merged;
    merged = row;
    merged[32*slice +: 32] = word;
    return merged;
  endfunction

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  assign paddr  = apb.paddr_i;
  assign pwdata = apb.pwdata_i;

  wire unused_paddr_hi = ^paddr[APB_ADDR_WIDTH-1:16];

  apb_state_e                  state_q, state_d;
  logic [APB_DATA_WIDTH-1:0]   prdata_q;
  logic                        pready_q;
  region_e                     region;
  logic [CH_MAP_ADDR_WIDTH-1:0] word_idx;
  logic [1:0]                  slice;
  logic                        map_region;
  logic                        out_of_range;
  logic                        start;
  logic [APB_DATA_WIDTH-1:0]   rdata_c;

  assign region       = region_e'(paddr[15:14]);
  assign word_idx     = paddr[2 +: CH_MAP_ADDR_WIDTH];
  assign slice        = paddr[3:2];
  assign map_region   = (region == REGION_CH_MAP) || (region == REGION_COL_MAP);
  assign out_of_range = map_region && (word_idx >= CH_MAP_ADDR_WIDTH'(CH_MAP_SIZE));
  assign start        = (state_q == IDLE) && apb.psel_i && apb.penable_i;

  // Addresses and write data follow the bus directly; APB holds them for the whole transfer.
  assign ch_map_addr_o  = word_idx;
  assign ch_map_data_o  = pwdata[CH_MAP_DATA_WIDTH-1:0];
  assign col_map_addr_o = paddr[2 +: COL_MAP_ADDR_WIDTH];
  assign col_map_data_o = pwdata[7:0];
  assign ch_t_rw_addr_o = paddr[4 +: CH_T_ADDR_WIDTH];
  assign ch_t_rw_data_o = rmw_merge(ch_t_rw_data_i, slice, pwdata);

  // Byte maps write in T0; glyph rows must wait for the old row to merge into, so they write in T1.
  assign ch_map_wen_o  = !rst_i && start && apb.pwrite_i && (region == REGION_CH_MAP) && !out_of_range;
  assign col_map_wen_o = !rst_i && start && apb.pwrite_i && (region == REGION_COL_MAP) && !out_of_range;
  assign ch_t_rw_wen_o = !rst_i && (state_q == WAIT) && apb.pwrite_i && (region == REGION_CH_T);

  always_comb begin
    rdata_c = '0;
    case (region)
      REGION_CH_MAP:  if (!out_of_range) rdata_c = APB_DATA_WIDTH'(ch_map_data_i);
      REGION_COL_MAP: if (!out_of_range) rdata_c = APB_DATA_WIDTH'(col_map_data_i);
      REGION_CH_T:    rdata_c = ch_t_rw_data_i[32*slice +: 32];
      REGION_CTRL:    if (paddr[13:0] == 14'd0) rdata_c = CTRL_ID;
      default:        rdata_c = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      prdata_q <= '0;
      pready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT) begin
        pready_q <= 1'b1;
        if (!apb.pwrite_i) prdata_q <= rdata_c;
      end else if (state_q == DONE) begin
        pready_q <= 1'b0;
      end
    end
  end

  assign apb.prdata_o = prdata_q;
  assign apb.pready_o = pready_q;

`ifdef VGACHARGEN_APB_PSLVERR_EN
  logic pslverr_q;
  logic err_c;
  assign err_c = out_of_range || ((region == REGION_CTRL) && apb.pwrite_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pslverr_q <= 1'b0;
    end else if (state_q == WAIT) begin
      pslverr_q <= err_c;
    end else if (state_q == DONE) begin
      pslverr_q <= 1'b0;
    end
  end

  assign apb.pslverr_o = pslverr_q;
`else
  assign apb.pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_vgachargen_apb_if.sv
// Self-checking bench: APB master tasks, BRAM models and a queue of expected transfer responses.
module tb_vgachargen_apb_if;
  import vgachargen_apb_if_pkg::*;

`ifdef VGACHARGEN_APB_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vgachargen_apb_if_if apb ();

  logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr;
  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_wdat;
  logic                          ch_map_wen;
  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_rdat;
  logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr;
  logic [7:0]                    col_map_wdat;
  logic                          col_map_wen;
  logic [7:0]                    col_map_rdat;
  logic [CH_T_ADDR_WIDTH-1:0]    ch_t_addr;
  logic [CH_T_DATA_WIDTH-1:0]    ch_t_wdat;
  logic                          ch_t_wen;
  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rdat;

  vgachargen_apb_if dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .apb            (apb),
    .ch_map_addr_o  (ch_map_addr),
    .ch_map_data_o  (ch_map_wdat),
    .ch_map_wen_o   (ch_map_wen),
    .ch_map_data_i  (ch_map_rdat),
    .col_map_addr_o (col_map_addr),
    .col_map_data_o (col_map_wdat),
    .col_map_wen_o  (col_map_wen),
    .col_map_data_i (col_map_rdat),
    .ch_t_rw_addr_o (ch_t_addr),
    .ch_t_rw_data_o (ch_t_wdat),
    .ch_t_rw_wen_o  (ch_t_wen),
    .ch_t_rw_data_i (ch_t_rdat)
  );

  // Read-first single-cycle BRAM models for port A
  logic [7:0]   ch_map_mem  [0:4095];
  logic [7:0]   col_map_mem [0:4095];
  logic [127:0] ch_t_mem    [0:255];
  int           wen_pulses = 0;

  always @(posedge clk) begin
    if (ch_map_wen)  ch_map_mem[ch_map_addr]   <= ch_map_wdat;
    if (col_map_wen) col_map_mem[col_map_addr] <= col_map_wdat;
    if (ch_t_wen)    ch_t_mem[ch_t_addr]       <= ch_t_wdat;
    ch_map_rdat  <= ch_map_mem[ch_map_addr];
    col_map_rdat <= col_map_mem[col_map_addr];
    ch_t_rdat    <= ch_t_mem[ch_t_addr];
    wen_pulses   <= wen_pulses + int'(ch_map_wen) + int'(col_map_wen) + int'(ch_t_wen);
  end

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    int          waits;
    int          wens;
    logic [2:0]  wen0;
    logic [2:0]  wen1;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;

  logic [31:0] o_rdata;
  logic        o_slverr;
  int          o_waits;
  int          o_wens;
  logic [2:0]  o_wen0;
  logic [2:0]  o_wen1;

  localparam logic [31:0] G0 = 32'hA0A0_0000;
  localparam logic [31:0] G1 = 32'hA1A1_1111;
  localparam logic [31:0] G2 = 32'hA2A2_2222;
  localparam logic [31:0] G3 = 32'hA3A3_3333;

  // One full APB transfer; records wen pattern in T0/T1, wait states and response.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat);
    int base;
    base = wen_pulses;
    @(posedge clk); #1;
    apb.psel_i    = 1'b1;
    apb.penable_i = 1'b0;
    apb.pwrite_i  = wr;
    apb.paddr_i   = addr;
    apb.pwdata_i  = wdat;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    #1;
    o_waits = 0;
    o_wen0  = {ch_map_wen, col_map_wen, ch_t_wen};
    o_wen1  = 3'b000;
    while (!apb.pready_o && o_waits < 10) begin
      @(posedge clk); #2;
      o_waits++;
      if (o_waits == 1) o_wen1 = {ch_map_wen, col_map_wen, ch_t_wen};
    end
    o_rdata  = apb.prdata_o;
    o_slverr = apb.pslverr_o;
    @(posedge clk); #1;
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
    o_wens = wen_pulses - base;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (apb.prdata_o !== 32'd0) $display("FAIL reset_prdata got=%h want=0", apb.prdata_o); else passed++;
    checks++; if (apb.pready_o !== 1'b0) $display("FAIL reset_pready got=%b want=0", apb.pready_o); else passed++;
    checks++; if (apb.pslverr_o !== 1'b0) $display("FAIL reset_pslverr got=%b want=0", apb.pslverr_o); else passed++;
    checks++;
    if ({ch_map_wen, col_map_wen, ch_t_wen} !== 3'b000)
      $display("FAIL reset_wen got=%b want=000", {ch_map_wen, col_map_wen, ch_t_wen});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_setup_only();
    int base;
    base = wen_pulses;
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_i = 32'h0000_0010; apb.pwdata_i = 32'h55;
    repeat (3) @(posedge clk);
    #1;
    apb.psel_i = 1'b0; apb.penable_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wen_pulses - base !== 0) $display("FAIL setup_only_wen got=%0d want=0", wen_pulses - base); else passed++;
    checks++; if (apb.pready_o !== 1'b0) $display("FAIL setup_only_pready got=%b want=0", apb.pready_o); else passed++;
    apb.penable_i = 1'b0;
  endtask

  task automatic test_ch_map();
    sb.push_back('{rdata: 32'h0, slverr: 1'b0, waits: 2, wens: 1, wen0: 3'b100, wen1: 3'b000});
    xfer(1'b1, 32'h0000_0014, 32'hFFFF_FF41);
    e = sb.pop_front();
    checks++; if (o_waits !== e.waits) $display("FAIL chmap_wr_waits got=%0d want=%0d", o_waits, e.waits); else passed++;
    checks++; if (o_wens !== e.wens) $display("FAIL chmap_wr_wens got=%0d want=%0d", o_wens, e.wens); else passed++;
    checks++; if (o_wen0 !== e.wen0) $display("FAIL chmap_wr_wen_t0 got=%b want=%b", o_wen0, e.wen0); else passed++;
    checks++; if (ch_map_mem[5] !== 8'h41) $display("FAIL chmap_mem5 got=%h want=41", ch_map_mem[5]); else passed++;
    sb.push_back('{rdata: 32'h41, slverr: 1'b0, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b0, 32'h0000_0014, 32'h0);
    e = sb.pop_front();
    checks++; if (o_rdata !== e.rdata) $display("FAIL chmap_rd_data got=%h want=%h", o_rdata, e.rdata); else passed++;
    checks++; if (o_waits !== e.waits) $display("FAIL chmap_rd_waits got=%0d want=%0d", o_waits, e.waits); else passed++;
  endtask

  task automatic test_col_map();
    sb.push_back('{rdata: 32'h0, slverr: 1'b0, waits: 2, wens: 1, wen0: 3'b010, wen1: 3'b000});
    xfer(1'b1, 32'h0000_4000, 32'h0000_00F0);
    e = sb.pop_front();
    checks++; if (o_wen0 !== e.wen0) $display("FAIL colmap_wr_wen_t0 got=%b want=%b", o_wen0, e.wen0); else passed++;
    checks++; if (o_wens !== e.wens) $display("FAIL colmap_wr_wens got=%0d want=%0d", o_wens, e.wens); else passed++;
    sb.push_back('{rdata: 32'hF0, slverr: 1'b0, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b0, 32'h0000_4000, 32'h0);
    e = sb.pop_front();
    checks++; if (o_rdata !== e.rdata) $display("FAIL colmap_rd_data got=%h want=%h", o_rdata, e.rdata); else passed++;
  endtask

  task automatic test_ch_t_rmw();
    logic [127:0] row;
    xfer(1'b1, 32'h0000_8030, G0);
    xfer(1'b1, 32'h0000_8034, G1);
    xfer(1'b1, 32'h0000_8038, G2);
    xfer(1'b1, 32'h0000_803C, G3);
    row = {G3, G2, G1, G0};
    checks++; if (ch_t_mem[3] !== row) $display("FAIL cht_preload got=%h want=%h", ch_t_mem[3], row); else passed++;
    row[95:64] = 32'hDEAD_BEEF;
    sb.push_back('{rdata: 32'h0, slverr: 1'b0, waits: 2, wens: 1, wen0: 3'b000, wen1: 3'b001});
    xfer(1'b1, 32'h0000_8038, 32'hDEAD_BEEF);
    e = sb.pop_front();
    checks++; if (o_wen0 !== e.wen0) $display("FAIL cht_wr_wen_t0 got=%b want=%b", o_wen0, e.wen0); else passed++;
    checks++; if (o_wen1 !== e.wen1) $display("FAIL cht_wr_wen_t1 got=%b want=%b", o_wen1, e.wen1); else passed++;
    checks++; if (o_wens !== e.wens) $display("FAIL cht_wr_wens got=%0d want=%0d", o_wens, e.wens); else passed++;
    checks++; if (o_waits !== e.waits) $display("FAIL cht_wr_waits got=%0d want=%0d", o_waits, e.waits); else passed++;
    checks++; if (ch_t_mem[3] !== row) $display("FAIL cht_merge got=%h want=%h", ch_t_mem[3], row); else passed++;
    sb.push_back('{rdata: 32'hDEAD_BEEF, slverr: 1'b0, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    sb.push_back('{rdata: G1, slverr: 1'b0, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b0, 32'h0000_8038, 32'h0);
    e = sb.pop_front();
    checks++; if (o_rdata !== e.rdata) $display("FAIL cht_rd_slice2 got=%h want=%h", o_rdata, e.rdata); else passed++;
    xfer(1'b0, 32'h0000_8034, 32'h0);
    e = sb.pop_front();
    checks++; if (o_rdata !== e.rdata) $display("FAIL cht_rd_slice1 got=%h want=%h", o_rdata, e.rdata); else passed++;
  endtask

  task automatic test_ctrl();
    sb.push_back('{rdata: CTRL_ID, slverr: 1'b0, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b0, 32'h0000_C000, 32'h0);
    e = sb.pop_front();
    checks++; if (o_rdata !== e.rdata) $display("FAIL ctrl_id got=%h want=%h", o_rdata, e.rdata); else passed++;
    checks++; if (o_slverr !== e.slverr) $display("FAIL ctrl_id_err got=%b want=%b", o_slverr, e.slverr); else passed++;
    sb.push_back('{rdata: 32'h0, slverr: 1'b0, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b0, 32'h0000_C004, 32'h0);
    e = sb.pop_front();
    checks++; if (o_rdata !== e.rdata) $display("FAIL ctrl_off4 got=%h want=%h", o_rdata, e.rdata); else passed++;
    sb.push_back('{rdata: 32'h0, slverr: ERR_EN, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b1, 32'h0000_C000, 32'h1234_5678);
    e = sb.pop_front();
    checks++; if (o_wens !== e.wens) $display("FAIL ctrl_wr_wens got=%0d want=%0d", o_wens, e.wens); else passed++;
    checks++; if (o_slverr !== e.slverr) $display("FAIL ctrl_wr_err got=%b want=%b", o_slverr, e.slverr); else passed++;
  endtask

  task automatic test_range();
    sb.push_back('{rdata: 32'h0, slverr: 1'b0, waits: 2, wens: 1, wen0: 3'b100, wen1: 3'b000});
    xfer(1'b1, 32'h0000_257C, 32'h0000_0066);
    e = sb.pop_front();
    checks++; if (o_wens !== e.wens) $display("FAIL range_last_wens got=%0d want=%0d", o_wens, e.wens); else passed++;
    checks++; if (o_slverr !== e.slverr) $display("FAIL range_last_err got=%b want=%b", o_slverr, e.slverr); else passed++;
    sb.push_back('{rdata: 32'h0, slverr: ERR_EN, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b1, 32'h0000_2580, 32'h0000_0077);
    e = sb.pop_front();
    checks++; if (o_wens !== e.wens) $display("FAIL range_oor_wens got=%0d want=%0d", o_wens, e.wens); else passed++;
    checks++; if (o_slverr !== e.slverr) $display("FAIL range_oor_wr_err got=%b want=%b", o_slverr, e.slverr); else passed++;
    sb.push_back('{rdata: 32'h0, slverr: ERR_EN, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b0, 32'h0000_6580, 32'h0);
    e = sb.pop_front();
    checks++; if (o_rdata !== e.rdata) $display("FAIL range_oor_rd got=%h want=%h", o_rdata, e.rdata); else passed++;
    checks++; if (o_slverr !== e.slverr) $display("FAIL range_oor_rd_err got=%b want=%b", o_slverr, e.slverr); else passed++;
  endtask

  task automatic test_back_to_back();
    sb.push_back('{rdata: 32'h41, slverr: 1'b0, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    sb.push_back('{rdata: 32'h0, slverr: 1'b0, waits: 2, wens: 1, wen0: 3'b010, wen1: 3'b000});
    xfer(1'b0, 32'h0000_0014, 32'h0);
    e = sb.pop_front();
    checks++; if (o_waits !== e.waits) $display("FAIL b2b_rd_waits got=%0d want=%0d", o_waits, e.waits); else passed++;
    checks++; if (o_rdata !== e.rdata) $display("FAIL b2b_rd_data got=%h want=%h", o_rdata, e.rdata); else passed++;
    checks++; if (o_wens !== e.wens) $display("FAIL b2b_rd_wens got=%0d want=%0d", o_wens, e.wens); else passed++;
    xfer(1'b1, 32'h0000_4004, 32'h0000_003C);
    e = sb.pop_front();
    checks++; if (o_waits !== e.waits) $display("FAIL b2b_wr_waits got=%0d want=%0d", o_waits, e.waits); else passed++;
    checks++; if (o_wens !== e.wens) $display("FAIL b2b_wr_wens got=%0d want=%0d", o_wens, e.wens); else passed++;
    checks++; if (col_map_mem[1] !== 8'h3C) $display("FAIL b2b_colmap1 got=%h want=3c", col_map_mem[1]); else passed++;
  endtask

  task automatic test_reset_mid();
    int base;
    base = wen_pulses;
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_i = 32'h0000_8030; apb.pwdata_i = 32'h1111_1111;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (ch_t_wen !== 1'b0) $display("FAIL rstmid_wen got=%b want=0", ch_t_wen); else passed++;
    @(posedge clk); #1;
    checks++; if (apb.pready_o !== 1'b0) $display("FAIL rstmid_pready got=%b want=0", apb.pready_o); else passed++;
    rst = 1'b0;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    checks++; if (wen_pulses - base !== 0) $display("FAIL rstmid_wens got=%0d want=0", wen_pulses - base); else passed++;
    sb.push_back('{rdata: G0, slverr: 1'b0, waits: 2, wens: 0, wen0: 3'b000, wen1: 3'b000});
    xfer(1'b0, 32'h0000_8030, 32'h0);
    e = sb.pop_front();
    checks++; if (o_rdata !== e.rdata) $display("FAIL rstmid_after_data got=%h want=%h", o_rdata, e.rdata); else passed++;
    checks++; if (o_waits !== e.waits) $display("FAIL rstmid_after_waits got=%0d want=%0d", o_waits, e.waits); else passed++;
  endtask

  initial begin
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
    apb.pwrite_i  = 1'b0;
    apb.paddr_i   = 32'h0;
    apb.pwdata_i  = 32'h0;
    test_reset();
    test_setup_only();
    test_ch_map();
    test_col_map();
    test_ch_t_rmw();
    test_ctrl();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
